// File: rtl/uart_bus_bridge.sv
// ---------------------------------------------------------------------------
// uart_bus_bridge
// Bus master driven by a UART byte stream. A host sends command frames
//    'W' A3 A2 A1 A0 D3 D2 D1 D0   or   'R' A3 A2 A1 A0   (MSB first)
// and the bridge performs one bus write or read, then replies with a status
// byte (ACK/NAK) followed, for a successful read, by the four read data bytes.
//
// Ports
//    i_Clk, i_Rst        clock (rising edge), asynchronous active-high reset
//    i_RxData/i_RxValid  received byte plus 1-cycle strobe
//    o_TxData/o_TxValid  reply byte; held stable until i_TxReady accepts it
//    i_TxReady           transmitter handshake
//    o_WEnable/o_WAddr/o_WData   1-cycle write strobe, address, data
//    o_REnable/o_RAddr           1-cycle read strobe, address
//    i_RData, i_Err      slave read data / error, sampled the cycle after a strobe
//    o_Busy              high whenever the bridge is not idle
//    o_Overrun           sticky flag: an RX byte arrived while not accepting
// ---------------------------------------------------------------------------
module uart_bus_bridge #(
   parameter int         TIMEOUT_CYCLES = 100000,
   parameter logic [7:0] ACK_BYTE       = 8'h06,
   parameter logic [7:0] NAK_BYTE       = 8'h15
) (
   input  logic        i_Clk,
   input  logic        i_Rst,
   input  logic [7:0]  i_RxData,
   input  logic        i_RxValid,
   output logic [7:0]  o_TxData,
   output logic        o_TxValid,
   input  logic        i_TxReady,
   output logic        o_WEnable,
   output logic [31:0] o_WAddr,
   output logic [31:0] o_WData,
   output logic        o_REnable,
   output logic [31:0] o_RAddr,
   input  logic [31:0] i_RData,
   input  logic        i_Err,
   output logic        o_Busy,
   output logic        o_Overrun
);

   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] CMD_READ  = 8'h52;
   localparam int         TW        = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE, ADDR, DATA, BUS_WR, BUS_RD, BUS_WAIT, TX_STATUS, TX_DATA
   } state_t;

   state_t        state, next_state;
   logic [1:0]    cnt;
   logic          cmd_read;
   logic          rd_ok;
   logic [31:0]   addr;
   logic [31:0]   wdata;
   logic [31:0]   rdata;
   logic [7:0]    status_byte;
   logic [TW-1:0] timer;
   logic          timeout_hit;

   // A byte arriving in the expiry cycle wins over the timeout.
   assign timeout_hit = (timer == TW'(TIMEOUT_CYCLES - 1)) && !i_RxValid;
   assign o_Busy      = (state != IDLE);

   // State register.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) state <= IDLE;
      else       state <= next_state;
   end

   // Next-state decode plus the strobe and TX outputs, which depend on state only
   // so the reply byte cannot move while the transmitter is stalling.
   always_comb begin
      next_state = state;
      o_WEnable  = 1'b0;
      o_REnable  = 1'b0;
      o_TxValid  = 1'b0;
      o_TxData   = 8'h00;
      case (state)
         IDLE: begin
            if (i_RxValid) begin
               if (i_RxData == CMD_WRITE || i_RxData == CMD_READ) next_state = ADDR;
               else                                               next_state = TX_STATUS;
            end
         end
         ADDR: begin
            if (i_RxValid && cnt == 2'd3) next_state = cmd_read ? BUS_RD : DATA;
            else if (timeout_hit)         next_state = IDLE;
         end
         DATA: begin
            if (i_RxValid && cnt == 2'd3) next_state = BUS_WR;
            else if (timeout_hit)         next_state = IDLE;
         end
         BUS_WR: begin
            o_WEnable  = 1'b1;
            next_state = BUS_WAIT;
         end
         BUS_RD: begin
            o_REnable  = 1'b1;
            next_state = BUS_WAIT;
         end
         BUS_WAIT: next_state = TX_STATUS;
         TX_STATUS: begin
            o_TxValid = 1'b1;
            o_TxData  = status_byte;
            if (i_TxReady) next_state = rd_ok ? TX_DATA : IDLE;
         end
         TX_DATA: begin
            o_TxValid = 1'b1;
            case (cnt)
               2'd0:    o_TxData = rdata[31:24];
               2'd1:    o_TxData = rdata[23:16];
               2'd2:    o_TxData = rdata[15:8];
               default: o_TxData = rdata[7:0];
            endcase
            if (i_TxReady && cnt == 2'd3) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Frame assembly, inter-byte timer, bus address/data latches and reply data.
   // The bus address/data outputs are loaded on the last frame byte so they are
   // already valid in the strobe cycle, and they hold until the next access.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         cnt         <= '0;
         cmd_read    <= 1'b0;
         rd_ok       <= 1'b0;
         addr        <= '0;
         wdata       <= '0;
         rdata       <= '0;
         status_byte <= '0;
         timer       <= '0;
         o_WAddr     <= '0;
         o_WData     <= '0;
         o_RAddr     <= '0;
         o_Overrun   <= 1'b0;
      end else begin
         if (i_RxValid && !(state inside {IDLE, ADDR, DATA})) o_Overrun <= 1'b1;
         case (state)
            IDLE: begin
               if (i_RxValid) begin
                  cnt   <= '0;
                  timer <= '0;
                  if (i_RxData == CMD_WRITE || i_RxData == CMD_READ) begin
                     cmd_read <= (i_RxData == CMD_READ);
                  end else begin
                     status_byte <= NAK_BYTE;
                     rd_ok       <= 1'b0;
                  end
               end
            end
            ADDR: begin
               if (i_RxValid) begin
                  addr  <= {addr[23:0], i_RxData};
                  cnt   <= cnt + 2'd1;
                  timer <= '0;
                  if (cnt == 2'd3 && cmd_read) o_RAddr <= {addr[23:0], i_RxData};
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            DATA: begin
               if (i_RxValid) begin
                  wdata <= {wdata[23:0], i_RxData};
                  cnt   <= cnt + 2'd1;
                  timer <= '0;
                  if (cnt == 2'd3) begin
                     o_WAddr <= addr;
                     o_WData <= {wdata[23:0], i_RxData};
                  end
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            BUS_WAIT: begin
               status_byte <= i_Err ? NAK_BYTE : ACK_BYTE;
               rd_ok       <= cmd_read && !i_Err;
               if (cmd_read) rdata <= i_RData;
            end
            TX_STATUS: begin
               if (i_TxReady) cnt <= '0;
            end
            TX_DATA: begin
               if (i_TxReady) cnt <= cnt + 2'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// ---------------------------------------------------------------------------
// tb_uart_bus_bridge
// Directed bench for uart_bus_bridge: writes, reads, error replies, unknown
// commands, inter-byte timeout (including the byte-wins boundary), transmit
// back-pressure with overrun, and asynchronous reset in the middle of a frame.
// ---------------------------------------------------------------------------
module tb_uart_bus_bridge;

   localparam int TIMEOUT = 20;

   logic        i_Clk = 1'b0;
   logic        i_Rst = 1'b0;
   logic [7:0]  i_RxData = 8'h00;
   logic        i_RxValid = 1'b0;
   logic [7:0]  o_TxData;
   logic        o_TxValid;
   logic        i_TxReady = 1'b1;
   logic        o_WEnable;
   logic [31:0] o_WAddr;
   logic [31:0] o_WData;
   logic        o_REnable;
   logic [31:0] o_RAddr;
   logic [31:0] i_RData = 32'h0;
   logic        i_Err = 1'b0;
   logic        o_Busy;
   logic        o_Overrun;

   int          checks = 0;
   int          errors = 0;
   int          wr_count = 0;
   int          rd_count = 0;
   logic [7:0]  tx_q[$];

   uart_bus_bridge #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
      .i_Clk(i_Clk), .i_Rst(i_Rst),
      .i_RxData(i_RxData), .i_RxValid(i_RxValid),
      .o_TxData(o_TxData), .o_TxValid(o_TxValid), .i_TxReady(i_TxReady),
      .o_WEnable(o_WEnable), .o_WAddr(o_WAddr), .o_WData(o_WData),
      .o_REnable(o_REnable), .o_RAddr(o_RAddr),
      .i_RData(i_RData), .i_Err(i_Err),
      .o_Busy(o_Busy), .o_Overrun(o_Overrun)
   );

   always #5 i_Clk = ~i_Clk;

   // Record strobes and accepted reply bytes on the falling edge, away from
   // the edge where the DUT updates.
   always @(negedge i_Clk) begin
      if (o_WEnable) wr_count++;
      if (o_REnable) rd_count++;
      if (o_TxValid && i_TxReady) tx_q.push_back(o_TxData);
   end

   // Hard stop in case something wedges the stimulus thread.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed=hung expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick;
      @(posedge i_Clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      i_RxData  = b;
      i_RxValid = 1'b1;
      tick();
      i_RxValid = 1'b0;
      i_RxData  = 8'h00;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) applyStimulus(w[31-8*i -: 8]);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (o_Busy && n < 200) begin
         tick();
         n++;
      end
      checkOutput({tag, "_idle"}, {31'd0, o_Busy}, 32'd0);
   endtask

   // Compare the captured reply stream against n bytes packed MSB first.
   task automatic check_reply(input string tag, input int n, input logic [39:0] bytes);
      logic [7:0] obs;
      checkOutput({tag, "_len"}, tx_q.size(), n);
      for (int i = 0; i < n; i++) begin
         obs = (i < tx_q.size()) ? tx_q[i] : 8'hEE;
         checkOutput($sformatf("%s_byte%0d", tag, i), {24'd0, obs}, {24'd0, bytes[39-8*i -: 8]});
      end
      tx_q.delete();
   endtask

   initial begin
      int wr0, rd0, bad;

      // ---------------- reset values ----------------
      #1 i_Rst = 1'b1;
      #2;
      checkOutput("rst_txvalid", {31'd0, o_TxValid}, 0);
      checkOutput("rst_txdata",  {24'd0, o_TxData}, 0);
      checkOutput("rst_wen",     {31'd0, o_WEnable}, 0);
      checkOutput("rst_ren",     {31'd0, o_REnable}, 0);
      checkOutput("rst_waddr",   o_WAddr, 0);
      checkOutput("rst_wdata",   o_WData, 0);
      checkOutput("rst_raddr",   o_RAddr, 0);
      checkOutput("rst_busy",    {31'd0, o_Busy}, 0);
      checkOutput("rst_overrun", {31'd0, o_Overrun}, 0);
      repeat (2) @(posedge i_Clk);
      #1 i_Rst = 1'b0;
      tick();

      // ---------------- write 0x00000000 <= 0x55 with exact latency ----------------
      applyStimulus(8'h57);
      send_word(32'h0000_0000);
      send_word(32'h0000_0055);
      checkOutput("w1_strobe", {31'd0, o_WEnable}, 1);
      checkOutput("w1_waddr",  o_WAddr, 32'h0);
      checkOutput("w1_wdata",  o_WData, 32'h55);
      tick();
      checkOutput("w1_strobe_off", {31'd0, o_WEnable}, 0);
      tick();
      checkOutput("w1_status_valid", {31'd0, o_TxValid}, 1);
      checkOutput("w1_status_byte",  {24'd0, o_TxData}, 32'h06);
      wait_idle("w1");
      checkOutput("w1_wr_count", wr_count, 1);
      check_reply("w1_reply", 1, 40'h06_00000000);

      // ---------------- write with nonzero address to pin byte order ----------------
      applyStimulus(8'h57);
      send_word(32'h1234_5678);
      send_word(32'hDEAD_BEEF);
      checkOutput("w2_strobe", {31'd0, o_WEnable}, 1);
      checkOutput("w2_waddr",  o_WAddr, 32'h1234_5678);
      checkOutput("w2_wdata",  o_WData, 32'hDEAD_BEEF);
      wait_idle("w2");
      checkOutput("w2_wr_count", wr_count, 2);
      checkOutput("w2_waddr_hold", o_WAddr, 32'h1234_5678);
      check_reply("w2_reply", 1, 40'h06_00000000);

      // ---------------- read 0x00000000 returning 0xA5 ----------------
      i_RData = 32'h0000_00A5;
      applyStimulus(8'h52);
      send_word(32'h0000_0000);
      checkOutput("r1_strobe", {31'd0, o_REnable}, 1);
      checkOutput("r1_raddr",  o_RAddr, 32'h0);
      wait_idle("r1");
      checkOutput("r1_rd_count", rd_count, 1);
      checkOutput("r1_wr_count", wr_count, 2);
      check_reply("r1_reply", 5, 40'h06_000000A5);

      // ---------------- read 0x00000007 with slave error ----------------
      i_Err = 1'b1;
      applyStimulus(8'h52);
      send_word(32'h0000_0007);
      checkOutput("r2_raddr", o_RAddr, 32'h7);
      wait_idle("r2");
      i_Err = 1'b0;
      checkOutput("r2_rd_count", rd_count, 2);
      check_reply("r2_reply", 1, 40'h15_00000000);

      // ---------------- unknown command byte ----------------
      applyStimulus(8'h41);
      wait_idle("bad");
      checkOutput("bad_wr_count", wr_count, 2);
      checkOutput("bad_rd_count", rd_count, 2);
      check_reply("bad_reply", 1, 40'h15_00000000);

      // ---------------- timeout: 'W' + 2 bytes then silence ----------------
      applyStimulus(8'h57);
      applyStimulus(8'h00);
      applyStimulus(8'h00);
      repeat (TIMEOUT - 1) tick();
      checkOutput("to_busy_before", {31'd0, o_Busy}, 1);
      tick();
      checkOutput("to_busy_after", {31'd0, o_Busy}, 0);
      repeat (5) tick();
      checkOutput("to_wr_count", wr_count, 2);
      checkOutput("to_tx_none", tx_q.size(), 0);

      // ---------------- byte arriving in the expiry cycle is kept ----------------
      applyStimulus(8'h57);
      applyStimulus(8'h00);
      repeat (TIMEOUT - 1) tick();
      applyStimulus(8'h00);
      checkOutput("edge_busy", {31'd0, o_Busy}, 1);
      applyStimulus(8'h00);
      applyStimulus(8'hC0);
      send_word(32'h0000_0001);
      checkOutput("edge_strobe", {31'd0, o_WEnable}, 1);
      checkOutput("edge_waddr",  o_WAddr, 32'h0000_00C0);
      checkOutput("edge_wdata",  o_WData, 32'h0000_0001);
      wait_idle("edge");
      check_reply("edge_reply", 1, 40'h06_00000000);

      // ---------------- back-pressure on read reply, overrun ----------------
      checkOutput("bp_overrun_pre", {31'd0, o_Overrun}, 0);
      i_RData   = 32'h1122_3344;
      i_TxReady = 1'b0;
      applyStimulus(8'h52);
      send_word(32'h0000_00B0);
      begin
         int n = 0;
         while (!o_TxValid && n < 20) begin
            tick();
            n++;
         end
      end
      checkOutput("bp_txvalid", {31'd0, o_TxValid}, 1);
      checkOutput("bp_status",  {24'd0, o_TxData}, 32'h06);
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         if (i == 25) applyStimulus(8'h99);
         else         tick();
         if (o_TxData !== 8'h06 || o_TxValid !== 1'b1) bad++;
      end
      checkOutput("bp_stable_status", bad, 0);
      checkOutput("bp_overrun", {31'd0, o_Overrun}, 1);
      i_TxReady = 1'b1;
      tick();
      tick();
      i_TxReady = 1'b0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (o_TxData !== 8'h22) bad++;
      end
      checkOutput("bp_stable_data", bad, 0);
      i_TxReady = 1'b1;
      wait_idle("bp");
      checkOutput("bp_overrun_sticky", {31'd0, o_Overrun}, 1);
      check_reply("bp_reply", 5, 40'h06_11223344);

      // ---------------- async reset after 6th byte of a write frame ----------------
      wr0 = wr_count;
      rd0 = rd_count;
      applyStimulus(8'h57);
      send_word(32'h0000_0001);
      applyStimulus(8'h00);
      checkOutput("mid_busy", {31'd0, o_Busy}, 1);
      #2 i_Rst = 1'b1;
      #1;
      checkOutput("mid_busy_rst",   {31'd0, o_Busy}, 0);
      checkOutput("mid_waddr_rst",  o_WAddr, 0);
      checkOutput("mid_wdata_rst",  o_WData, 0);
      checkOutput("mid_raddr_rst",  o_RAddr, 0);
      checkOutput("mid_overrun_rst", {31'd0, o_Overrun}, 0);
      checkOutput("mid_txvalid_rst", {31'd0, o_TxValid}, 0);
      repeat (3) @(posedge i_Clk);
      #1 i_Rst = 1'b0;
      tick();
      checkOutput("mid_no_strobe", wr_count - wr0 + rd_count - rd0, 0);
      checkOutput("mid_no_tx", tx_q.size(), 0);

      applyStimulus(8'h57);
      send_word(32'h0000_000A);
      send_word(32'h0000_00BB);
      checkOutput("post_strobe", {31'd0, o_WEnable}, 1);
      checkOutput("post_waddr",  o_WAddr, 32'h0000_000A);
      checkOutput("post_wdata",  o_WData, 32'h0000_00BB);
      wait_idle("post");
      checkOutput("post_wr_count", wr_count - wr0, 1);
      check_reply("post_reply", 1, 40'h06_00000000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
